// File: rtl/estado_mascota_pkg.sv
// ============================================================================
// Module   : estado_mascota_pkg
// Brief    : Pet state codes, level limits and zero-level counting helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package estado_mascota_pkg;

    localparam logic [2:0] FELIZ      = 3'd0;
    localparam logic [2:0] NEUTRAL    = 3'd1;
    localparam logic [2:0] TRISTE     = 3'd2;
    localparam logic [2:0] CANSADO    = 3'd3;
    localparam logic [2:0] HAMBRIENTO = 3'd4;
    localparam logic [2:0] ENFERMO    = 3'd5;
    localparam logic [2:0] MUERTO     = 3'd6;

    localparam logic [1:0] NIVEL_MIN = 2'd0;
    localparam logic [1:0] NIVEL_MAX = 2'd3;

    function automatic logic [2:0] contar_ceros(
        input logic [1:0] a,
        input logic [1:0] e,
        input logic [1:0] d,
        input logic [1:0] m
    );
        contar_ceros = {2'b00, (a == NIVEL_MIN)} + {2'b00, (e == NIVEL_MIN)}
                     + {2'b00, (d == NIVEL_MIN)} + {2'b00, (m == NIVEL_MIN)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/estado_mascota_contador.sv
// ============================================================================
// Module   : contador_estable
// Brief    : Saturating counter; o_tope flags the cycle whose count hits LIMITE-1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module contador_estable #(
    parameter int unsigned LIMITE = 4,
    parameter int          CNT_W  = 31
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tope
);

    localparam logic [CNT_W-1:0] C_TOPE = CNT_W'(LIMITE - 1);

    logic [CNT_W-1:0] r_cuenta;
    logic [CNT_W-1:0] w_base;

    // Clear drops the history; enable in the same cycle still counts that cycle.
    assign w_base = i_clr ? '0 : r_cuenta;
    assign o_tope = i_en && (w_base == C_TOPE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cuenta <= '0;
        end else if (i_en) begin
            r_cuenta <= (w_base == C_TOPE) ? C_TOPE : w_base + CNT_W'(1);
        end else if (i_clr) begin
            r_cuenta <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/estado_mascota.sv
// ============================================================================
// Module   : estado_mascota
// Brief    : Pet emotional/health state with hysteresis, death and test stepping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module estado_mascota
    import estado_mascota_pkg::*;
#(
    parameter int unsigned ESTABLE_CICLOS = 50000000,
    parameter int unsigned TIEMPO_MUERTE  = 1500000000,
    parameter int          CNT_W          = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] nivel_animo,
    input  logic [1:0] nivel_energia,
    input  logic [1:0] nivel_descanso,
    input  logic [1:0] nivel_medicina,
    input  logic       modo_test,
    input  logic       paso_test,
    output logic [2:0] estado,
    output logic       cambio_estado,
    output logic       activo_comida,
    output logic       activo_medicina
);

    logic [2:0] r_estado;
    logic [2:0] r_guardado;
    logic [2:0] r_cand_prev;
    logic       r_modo_prev;
    logic       r_cambio;
    logic       r_comida;
    logic       r_medicina;

    logic [2:0] w_cand;
    logic [2:0] w_sig;
    logic [2:0] w_ceros;
    logic       w_salida;
    logic       w_estab_clr;
    logic       w_estab_en;
    logic       w_estab_tope;
    logic       w_muerte_clr;
    logic       w_muerte_en;
    logic       w_muerte_tope;

    always_comb begin
        if (nivel_medicina == NIVEL_MIN) begin
            w_cand = ENFERMO;
        end else if (nivel_energia == NIVEL_MIN) begin
            w_cand = HAMBRIENTO;
        end else if (nivel_descanso == NIVEL_MIN) begin
            w_cand = CANSADO;
        end else if (nivel_animo == NIVEL_MIN) begin
            w_cand = TRISTE;
        end else if (nivel_animo[1] && nivel_energia[1] && nivel_descanso[1] && nivel_medicina[1]) begin
            w_cand = FELIZ;
        end else begin
            w_cand = NEUTRAL;
        end
    end

    assign w_ceros  = contar_ceros(nivel_animo, nivel_energia, nivel_descanso, nivel_medicina);
    assign w_salida = r_modo_prev && !modo_test;

    // Both counters hold their value while modo_test is high.
    assign w_estab_clr  = !modo_test && (w_salida || (w_cand == r_estado) || (w_cand != r_cand_prev));
    assign w_estab_en   = !modo_test && !w_salida && (w_cand != r_estado) && (r_estado != MUERTO);
    assign w_muerte_clr = !modo_test && (w_ceros < 3'd2);
    assign w_muerte_en  = !modo_test && (w_ceros >= 3'd2);

    contador_estable #(
        .LIMITE (ESTABLE_CICLOS),
        .CNT_W  (CNT_W)
    ) u_estable (
        .clk    (clk),
        .rst    (reset),
        .i_clr  (w_estab_clr),
        .i_en   (w_estab_en),
        .o_tope (w_estab_tope)
    );

    contador_estable #(
        .LIMITE (TIEMPO_MUERTE),
        .CNT_W  (CNT_W)
    ) u_muerte (
        .clk    (clk),
        .rst    (reset),
        .i_clr  (w_muerte_clr),
        .i_en   (w_muerte_en),
        .o_tope (w_muerte_tope)
    );

    always_comb begin
        w_sig = r_estado;
        if (modo_test) begin
            if (paso_test) begin
                w_sig = (r_estado == MUERTO) ? FELIZ : r_estado + 3'd1;
            end
        end else begin
            // On exit the saved code is the baseline; death outranks adoption.
            w_sig = w_salida ? r_guardado : r_estado;
            if (w_sig != MUERTO) begin
                if (w_muerte_tope) begin
                    w_sig = MUERTO;
                end else if (w_estab_tope) begin
                    w_sig = w_cand;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado    <= FELIZ;
            r_guardado  <= FELIZ;
            r_cand_prev <= FELIZ;
            r_modo_prev <= 1'b0;
            r_cambio    <= 1'b0;
            r_comida    <= 1'b0;
            r_medicina  <= 1'b0;
        end else begin
            r_estado    <= w_sig;
            r_cambio    <= (w_sig != r_estado);
            r_cand_prev <= w_cand;
            r_modo_prev <= modo_test;
            if (modo_test && !r_modo_prev) begin
                r_guardado <= r_estado;
            end
            r_comida    <= !modo_test && (nivel_energia < NIVEL_MAX) && (w_sig != MUERTO);
            r_medicina  <= !modo_test && (nivel_medicina < NIVEL_MAX) && (w_sig != MUERTO);
        end
    end

    assign estado          = r_estado;
    assign cambio_estado   = r_cambio;
    assign activo_comida   = r_comida;
    assign activo_medicina = r_medicina;

endmodule

`default_nettype wire

// File: tb/tb_estado_mascota.sv
// ============================================================================
// Module   : tb_estado_mascota
// Brief    : Vector table plus hand sequences for estado_mascota (E=4, T=20).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_estado_mascota;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] nivel_animo = 2'd3;
    logic [1:0] nivel_energia = 2'd3;
    logic [1:0] nivel_descanso = 2'd3;
    logic [1:0] nivel_medicina = 2'd3;
    logic       modo_test = 1'b0;
    logic       paso_test = 1'b0;
    logic [2:0] estado;
    logic       cambio_estado;
    logic       activo_comida;
    logic       activo_medicina;

    always #5 clk = ~clk;

    estado_mascota #(
        .ESTABLE_CICLOS (4),
        .TIEMPO_MUERTE  (20),
        .CNT_W          (31)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .nivel_animo     (nivel_animo),
        .nivel_energia   (nivel_energia),
        .nivel_descanso  (nivel_descanso),
        .nivel_medicina  (nivel_medicina),
        .modo_test       (modo_test),
        .paso_test       (paso_test),
        .estado          (estado),
        .cambio_estado   (cambio_estado),
        .activo_comida   (activo_comida),
        .activo_medicina (activo_medicina)
    );

    typedef struct {
        logic       rst;
        logic [1:0] a, e, d, m;
        logic       mt, pt;
        logic [2:0] est;
        logic       cam, com, med;
    } vec_t;

    vec_t       tabla[$];
    logic [5:0] sb[$];
    int         checks = 0;
    int         failures = 0;

    function automatic vec_t mk(input logic rst, input logic [1:0] a, input logic [1:0] e,
                                input logic [1:0] d, input logic [1:0] m, input logic mt,
                                input logic pt, input logic [2:0] est, input logic cam,
                                input logic com, input logic med);
        vec_t r;
        r.rst = rst; r.a = a; r.e = e; r.d = d; r.m = m; r.mt = mt; r.pt = pt;
        r.est = est; r.cam = cam; r.com = com; r.med = med;
        return r;
    endfunction

    task automatic comparar(input string nombre, input logic [5:0] esp);
        logic [5:0] act;
        act = {estado, cambio_estado, activo_comida, activo_medicina};
        checks++;
        if (act !== esp) begin
            failures++;
            $display("FAIL %s: got estado=%0d cambio=%0b comida=%0b medicina=%0b, want estado=%0d cambio=%0b comida=%0b medicina=%0b",
                     nombre, act[5:3], act[2], act[1], act[0], esp[5:3], esp[2], esp[1], esp[0]);
        end
    endtask

    // Inputs change on the falling edge; results are popped 1 ns after the rising edge.
    task automatic aplicar(input vec_t v, input string nombre);
        logic [5:0] esp;
        @(negedge clk);
        nivel_animo = v.a; nivel_energia = v.e; nivel_descanso = v.d; nivel_medicina = v.m;
        modo_test = v.mt; paso_test = v.pt;
        esp = {v.est, v.cam, v.com, v.med};
        if (v.rst) begin
            #2 reset = 1'b1;
            #1 comparar({nombre, "_async"}, esp);
            #1 reset = 1'b0;
        end
        sb.push_back(esp);
        @(posedge clk);
        #1;
        comparar(nombre, sb.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want bench completion");
        $fatal(1);
    end

    initial begin
        // Reset and idle with all levels full
        tabla.push_back(mk(1, 3,3,3,3, 0,0, 0,0,0,0));
        tabla.push_back(mk(0, 3,3,3,3, 0,0, 0,0,0,0));
        // energia drops: HAMBRIENTO after exactly 4 edges
        for (int i = 0; i < 3; i++) tabla.push_back(mk(0, 3,0,3,3, 0,0, 0,0,1,0));
        tabla.push_back(mk(0, 3,0,3,3, 0,0, 4,1,1,0));
        tabla.push_back(mk(0, 3,0,3,3, 0,0, 4,0,1,0));
        // Reset from HAMBRIENTO, then TRISTE candidate superseded by CANSADO
        tabla.push_back(mk(1, 3,3,3,3, 0,0, 0,0,0,0));
        for (int i = 0; i < 2; i++) tabla.push_back(mk(0, 0,3,3,3, 0,0, 0,0,0,0));
        for (int i = 0; i < 3; i++) tabla.push_back(mk(0, 0,3,0,3, 0,0, 0,0,0,0));
        tabla.push_back(mk(0, 0,3,0,3, 0,0, 3,1,0,0));
        tabla.push_back(mk(0, 0,3,0,3, 0,0, 3,0,0,0));
        // NEUTRAL, then test-mode stepping through all codes
        tabla.push_back(mk(1, 3,3,3,3, 0,0, 0,0,0,0));
        for (int i = 0; i < 3; i++) tabla.push_back(mk(0, 1,1,3,2, 0,0, 0,0,1,1));
        tabla.push_back(mk(0, 1,1,3,2, 0,0, 1,1,1,1));
        tabla.push_back(mk(0, 1,1,3,2, 1,0, 1,0,0,0));
        for (int s = 2; s <= 8; s++) begin
            tabla.push_back(mk(0, 1,1,3,2, 1,1, 3'(s % 7),1,0,0));
            tabla.push_back(mk(0, 1,1,3,2, 1,0, 3'(s % 7),0,0,0));
        end
        // Exit with a simultaneous step (dropped), then a step while not in test mode
        tabla.push_back(mk(0, 1,1,3,2, 0,1, 1,0,1,1));
        tabla.push_back(mk(0, 1,1,3,2, 0,1, 1,0,1,1));
        tabla.push_back(mk(0, 1,1,3,2, 0,0, 1,0,1,1));

        foreach (tabla[i]) aplicar(tabla[i], $sformatf("vec[%0d]", i));

        // Death with medicina and energia at 0; MUERTO is absorbing
        aplicar(mk(1, 3,3,3,3, 0,0, 0,0,0,0), "reset_muerte");
        for (int i = 1; i <= 20; i++)
            aplicar(mk(0, 3,0,3,0, 0,0, (i < 4) ? 3'd0 : ((i < 20) ? 3'd5 : 3'd6),
                       (i == 4) || (i == 20), i < 20, i < 20), $sformatf("muerte[%0d]", i));
        aplicar(mk(0, 3,0,3,0, 0,0, 6,0,0,0), "muerto_niveles_bajos");
        for (int i = 0; i < 6; i++)
            aplicar(mk(0, 3,3,3,3, 0,0, 6,0,0,0), $sformatf("muerto_absorbe[%0d]", i));

        // Death counter freezes during test mode and resumes afterwards
        aplicar(mk(1, 3,3,3,3, 0,0, 0,0,0,0), "reset_desde_muerto");
        for (int i = 1; i <= 10; i++)
            aplicar(mk(0, 3,0,3,0, 0,0, (i < 4) ? 3'd0 : 3'd5, i == 4, 1, 1),
                    $sformatf("pre_test[%0d]", i));
        for (int k = 1; k <= 50; k++)
            aplicar(mk(0, 3,0,3,0, 1, k == 25, (k < 25) ? 3'd5 : 3'd6, k == 25, 0, 0),
                    $sformatf("congelado[%0d]", k));
        for (int j = 1; j <= 10; j++)
            aplicar(mk(0, 3,0,3,0, 0,0, (j < 10) ? 3'd5 : 3'd6, (j == 1) || (j == 10),
                       j < 10, j < 10), $sformatf("reanuda[%0d]", j));

        // Death threshold coinciding with a hysteresis adoption
        aplicar(mk(1, 3,3,3,3, 0,0, 0,0,0,0), "reset_simultaneo");
        for (int i = 1; i <= 16; i++)
            aplicar(mk(0, 3,0,0,3, 0,0, (i < 4) ? 3'd0 : 3'd4, i == 4, 1, 0),
                    $sformatf("simul_a[%0d]", i));
        for (int i = 17; i <= 20; i++)
            aplicar(mk(0, 3,3,0,0, 0,0, (i < 20) ? 3'd4 : 3'd6, i == 20, 0, i < 20),
                    $sformatf("simul_b[%0d]", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
